// File: rtl/seven_segment_mux_if.sv
// seven_segment_mux_if
//   Bundles the data/control signals between the frequency-counter stage and
//   the two-digit seven-segment multiplexer.
//
//   Signals
//     load        counter stage -> mux : one-cycle strobe, counts valid when high
//     ten_count   counter stage -> mux : BCD tens value
//     unit_count  counter stage -> mux : BCD units value
//     blank_lead  counter stage -> mux : blank a zero tens digit (sampled live)
//     segments    mux -> display       : {g,f,e,d,c,b,a}, 1 = segment lit
//     digit       mux -> display       : 0 = units driven, 1 = tens driven
//     load_ack    mux -> counter stage : one-cycle pulse when pending data goes live
//
//   Handshake: load is a fire-and-forget strobe with no ready. Every load is
//   accepted; a later load overwrites an untransferred one. load_ack marks the
//   frame boundary at which the most recent pending value became visible.
//
//   Modports
//     master : the frequency-counter stage (drives load/counts/blank_lead)
//     slave  : the display multiplexer
interface seven_segment_mux_if;
    logic       load;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       blank_lead;
    logic [6:0] segments;
    logic       digit;
    logic       load_ack;

    modport master (
        output load, ten_count, unit_count, blank_lead,
        input  segments, digit, load_ack
    );

    modport slave (
        input  load, ten_count, unit_count, blank_lead,
        output segments, digit, load_ack
    );
endinterface

// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Time-multiplexes a two-digit BCD value onto one seven-segment display.
//   New values are staged in pending registers and only become active on a
//   frame boundary (digit 1->0), so a frame never shows a torn value.
//
//   Ports
//     clk      : single clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : seven_segment_mux_if.slave (load, counts, blank_lead in;
//                segments, digit, load_ack out)
//
//   Parameter
//     MUX_PERIOD : cycles each digit is driven (2..4095)
module seven_segment_mux #(
    parameter int MUX_PERIOD = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seven_segment_mux_if.slave   bus
);

    localparam logic [11:0] CNT_LAST = 12'(MUX_PERIOD - 1);

    logic [11:0] cnt_q,        cnt_d;
    logic        digit_q,      digit_d;
    logic [3:0]  pend_tens_q,  pend_tens_d;
    logic [3:0]  pend_units_q, pend_units_d;
    logic        pend_flag_q,  pend_flag_d;
    logic [3:0]  act_tens_q,   act_tens_d;
    logic [3:0]  act_units_q,  act_units_d;
    logic        load_ack_q,   load_ack_d;

    logic        cnt_wrap;
    logic        frame_edge;
    logic [3:0]  sel_value;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;  // non-BCD input shows a dash
        endcase
        return seg;
    endfunction

    assign cnt_wrap   = (cnt_q == CNT_LAST);
    // Frame boundary: the edge on which digit returns from tens (1) to units (0).
    assign frame_edge = cnt_wrap && digit_q;

    always_comb begin
        cnt_d        = cnt_wrap ? 12'd0 : cnt_q + 12'd1;
        digit_d      = cnt_wrap ? ~digit_q : digit_q;
        pend_tens_d  = pend_tens_q;
        pend_units_d = pend_units_q;
        pend_flag_d  = pend_flag_q;
        act_tens_d   = act_tens_q;
        act_units_d  = act_units_q;
        load_ack_d   = 1'b0;

        // Transfer reads the pre-edge pending contents, so a load landing on
        // the same edge is kept for the following frame instead of lost.
        if (frame_edge && pend_flag_q) begin
            act_tens_d  = pend_tens_q;
            act_units_d = pend_units_q;
            pend_flag_d = 1'b0;
            load_ack_d  = 1'b1;
        end

        if (bus.load) begin
            pend_tens_d  = bus.ten_count;
            pend_units_d = bus.unit_count;
            pend_flag_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= 12'd0;
            digit_q      <= 1'b0;
            pend_tens_q  <= 4'd0;
            pend_units_q <= 4'd0;
            pend_flag_q  <= 1'b0;
            act_tens_q   <= 4'd0;
            act_units_q  <= 4'd0;
            load_ack_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            pend_tens_q  <= pend_tens_d;
            pend_units_q <= pend_units_d;
            pend_flag_q  <= pend_flag_d;
            act_tens_q   <= act_tens_d;
            act_units_q  <= act_units_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign sel_value = digit_q ? act_tens_q : act_units_q;

    // Leading-zero blanking applies to the tens digit only and uses the live
    // blank_lead input.
    assign bus.segments = (digit_q && bus.blank_lead && (act_tens_q == 4'd0))
                          ? 7'h00 : decode(sel_value);
    assign bus.digit    = digit_q;
    assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with MUX_PERIOD = 4.
// Phase index k counts rising edges since reset release (sampled 1 ns after
// each edge): digit = (k/4)%2, and frame boundaries land at k = 8, 16, 24, ...
module tb_seven_segment_mux;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    seven_segment_mux_if bus ();

    seven_segment_mux #(.MUX_PERIOD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.ten_count  = 4'd0;
        bus.unit_count = 4'd0;
        bus.blank_lead = 1'b0;
        step();
        step();
        reset_n = 1'b1;  // now at k = 0
    endtask

    task automatic drive_load(input logic [3:0] t, input logic [3:0] u);
        bus.load       = 1'b1;
        bus.ten_count  = t;
        bus.unit_count = u;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic exp_digit;
        reset_n  = 1'b0;
        bus.load = 1'b0;
        bus.blank_lead = 1'b0;
        step();
        checks++;
        if (bus.segments !== 7'h3F || bus.digit !== 1'b0 || bus.load_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: seg=%h digit=%b ack=%b required seg=3f digit=0 ack=0",
                     bus.segments, bus.digit, bus.load_ack);
        end
        do_reset();
        for (int k = 0; k < 16; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            checks++;
            if (bus.segments !== 7'h3F || bus.digit !== exp_digit || bus.load_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d: seg=%h digit=%b ack=%b required seg=3f digit=%b ack=0",
                         k, bus.segments, bus.digit, bus.load_ack, exp_digit);
            end
            step();
        end
    endtask

    task automatic test_load_mid();
        logic       exp_digit;
        logic [6:0] exp_seg;
        do_reset();
        step();                       // k = 1
        drive_load(4'd4, 4'd2);
        step();                       // k = 2
        bus.load = 1'b0;
        for (int k = 2; k < 16; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            exp_seg   = (k < 8) ? 7'h3F : (exp_digit ? 7'h66 : 7'h5B);
            checks++;
            if (bus.segments !== exp_seg || bus.digit !== exp_digit || bus.load_ack !== (k == 8)) begin
                errors++;
                $display("FAIL load_mid k=%0d: seg=%h digit=%b ack=%b required seg=%h digit=%b ack=%b",
                         k, bus.segments, bus.digit, bus.load_ack, exp_seg, exp_digit, (k == 8));
            end
            step();
        end
    endtask

    task automatic test_last_write_wins();
        logic       exp_digit;
        logic [6:0] exp_seg;
        do_reset();
        step();                       // k = 1
        drive_load(4'd1, 4'd3);
        step();                       // k = 2
        drive_load(4'd7, 4'd9);
        step();                       // k = 3
        bus.load = 1'b0;
        for (int k = 3; k < 20; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            exp_seg   = (k < 8) ? 7'h3F : (exp_digit ? 7'h07 : 7'h6F);
            checks++;
            if (bus.segments !== exp_seg || bus.digit !== exp_digit || bus.load_ack !== (k == 8)) begin
                errors++;
                $display("FAIL last_write k=%0d: seg=%h digit=%b ack=%b required seg=%h digit=%b ack=%b",
                         k, bus.segments, bus.digit, bus.load_ack, exp_seg, exp_digit, (k == 8));
            end
            step();
        end
    endtask

    task automatic test_blank_lead();
        logic       exp_digit;
        logic [6:0] exp_seg;
        do_reset();
        drive_load(4'd0, 4'd5);
        bus.blank_lead = 1'b1;
        step();                       // k = 1
        bus.load = 1'b0;
        for (int k = 1; k < 24; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            if (!exp_digit)  exp_seg = (k < 8) ? 7'h3F : 7'h6D;
            else if (k < 16) exp_seg = 7'h00;   // zero tens blanked, before and after load
            else             exp_seg = 7'h3F;   // blank_lead dropped at k = 15
            checks++;
            if (bus.segments !== exp_seg || bus.digit !== exp_digit || bus.load_ack !== (k == 8)) begin
                errors++;
                $display("FAIL blank_lead k=%0d: seg=%h digit=%b ack=%b required seg=%h digit=%b ack=%b",
                         k, bus.segments, bus.digit, bus.load_ack, exp_seg, exp_digit, (k == 8));
            end
            if (k == 15) bus.blank_lead = 1'b0;
            step();
        end
    endtask

    task automatic test_dash();
        logic       exp_digit;
        logic [6:0] exp_seg;
        do_reset();
        drive_load(4'd12, 4'd10);
        step();                       // k = 1
        bus.load = 1'b0;
        for (int k = 1; k < 16; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            exp_seg   = (k < 8) ? 7'h3F : 7'h40;
            checks++;
            if (bus.segments !== exp_seg || bus.digit !== exp_digit || bus.load_ack !== (k == 8)) begin
                errors++;
                $display("FAIL dash k=%0d: seg=%h digit=%b ack=%b required seg=%h digit=%b ack=%b",
                         k, bus.segments, bus.digit, bus.load_ack, exp_seg, exp_digit, (k == 8));
            end
            step();
        end
    endtask

    // Second load lands exactly on the frame-boundary edge (driven during k = 7).
    task automatic test_back_to_back();
        logic       exp_digit;
        logic       exp_ack;
        logic [6:0] exp_seg;
        do_reset();
        drive_load(4'd1, 4'd2);
        step();                       // k = 1
        bus.load = 1'b0;
        for (int k = 1; k < 28; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            exp_ack   = (k == 8) || (k == 16);
            if (k < 8)       exp_seg = 7'h3F;
            else if (k < 16) exp_seg = exp_digit ? 7'h06 : 7'h5B;
            else             exp_seg = exp_digit ? 7'h4F : 7'h66;
            checks++;
            if (bus.segments !== exp_seg || bus.digit !== exp_digit || bus.load_ack !== exp_ack) begin
                errors++;
                $display("FAIL back_to_back k=%0d: seg=%h digit=%b ack=%b required seg=%h digit=%b ack=%b",
                         k, bus.segments, bus.digit, bus.load_ack, exp_seg, exp_digit, exp_ack);
            end
            if (k == 7) drive_load(4'd3, 4'd4);
            else        bus.load = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_discard();
        logic exp_digit;
        do_reset();
        drive_load(4'd8, 4'd8);
        step();                       // k = 1
        bus.load = 1'b0;
        step();
        step();                       // k = 3, pending set
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.segments !== 7'h3F || bus.digit !== 1'b0 || bus.load_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: seg=%h digit=%b ack=%b required seg=3f digit=0 ack=0",
                     bus.segments, bus.digit, bus.load_ack);
        end
        drive_load(4'd5, 4'd5);       // load during reset must be ignored
        step();
        step();
        bus.load = 1'b0;
        step();
        reset_n = 1'b1;               // k = 0
        for (int k = 0; k < 20; k++) begin
            exp_digit = ((k / 4) % 2) == 1;
            checks++;
            if (bus.segments !== 7'h3F || bus.digit !== exp_digit || bus.load_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard k=%0d: seg=%h digit=%b ack=%b required seg=3f digit=%b ack=0",
                         k, bus.segments, bus.digit, bus.load_ack, exp_digit);
            end
            step();
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.ten_count  = 4'd0;
        bus.unit_count = 4'd0;
        bus.blank_lead = 1'b0;
        test_reset();
        test_load_mid();
        test_last_write_wins();
        test_blank_lead();
        test_dash();
        test_back_to_back();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
